// File: rtl/pipe_ctrl_param.sv
// Central pipeline controller: per-stage ready/flush, halt/run/single-step FSM,
// display-load strobe and saturating stall/cycle performance counters.
module pipe_ctrl_param #(
  parameter int          NSTAGES   = 5,
  parameter int          STALL_AT  = 2,
  parameter logic [31:0] DISP_CODE = 32'h22,
  parameter int          CNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NSTAGES-1:0] stage_valid,
  output logic [NSTAGES-1:0] stage_ready,
  output logic [NSTAGES-1:0] stage_flush,
  input  logic               stall_req,
  input  logic [NSTAGES-1:0] flush_req,
  input  logic               sys_req,
  input  logic [31:0]        sys_code,
  input  logic               go,
  input  logic               step,
  output logic               halted,
  output logic               disp_load,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   cycle_cnt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_STEP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             all_v;
  logic             adv;
  logic             sys_halt;

  assign all_v     = &stage_valid;
  assign adv       = all_v & ((state_q == S_RUN) | (state_q == S_STEP));
  assign sys_halt  = sys_req & (sys_code != DISP_CODE);
  assign disp_load = sys_req & (sys_code == DISP_CODE) & adv;
  assign halted    = (state_q == S_HALTED);
  assign cycle_cnt = cycle_cnt_q;
  assign stall_cnt = stall_cnt_q;

  // Stages ahead of the stall point hold; the stall point itself takes a bubble.
  always_comb begin
    stage_ready = '0;
    stage_flush = '0;
    for (int i = 0; i < NSTAGES; i++) begin
      stage_ready[i] = adv & ~(stall_req & (i < STALL_AT));
      stage_flush[i] = flush_req[i] | (stall_req & (i == STALL_AT));
    end
  end

  // A halting syscall that advances in STEP wins over a concurrent go.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (adv & sys_halt) state_d = S_HALTED;
        else                state_d = S_RUN;
      end
      S_HALTED: begin
        if (go)        state_d = S_RUN;
        else if (step) state_d = S_STEP;
        else           state_d = S_HALTED;
      end
      S_STEP: begin
        if (adv & sys_halt) state_d = S_HALTED;
        else if (go)        state_d = S_RUN;
        else if (adv)       state_d = S_HALTED;
        else                state_d = S_STEP;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (adv && (cycle_cnt_q != {CNT_W{1'b1}})) begin
      cycle_cnt_d = cycle_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end
    if (adv && stall_req && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      cycle_cnt_q <= {CNT_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_param.sv
// Bench for pipe_ctrl_param: directed stimulus, a behavioural model checked every
// cycle against a 32-bit-counter and a 4-bit-counter instance, plus pinned literals.
module tb_pipe_ctrl_param;

  localparam int NS = 5;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] stage_valid;
  logic          stall_req;
  logic [NS-1:0] flush_req;
  logic          sys_req;
  logic [31:0]   sys_code;
  logic          go;
  logic          step;

  logic [NS-1:0] stage_ready, stage_flush;
  logic          halted, disp_load;
  logic [31:0]   stall_cnt, cycle_cnt;

  logic [NS-1:0] stage_ready4, stage_flush4;
  logic          halted4, disp_load4;
  logic [3:0]    stall_cnt4, cycle_cnt4;

  int total = 0;
  int bad   = 0;

  // model: halted flag, single-step flag, unbounded event counts
  bit     m_halt = 1'b0;
  bit     m_step = 1'b0;
  longint m_cnt  = 0;
  longint m_scnt = 0;

  pipe_ctrl_param u_dut (
    .clk(clk), .rst_n(rst_n), .stage_valid(stage_valid),
    .stage_ready(stage_ready), .stage_flush(stage_flush),
    .stall_req(stall_req), .flush_req(flush_req),
    .sys_req(sys_req), .sys_code(sys_code), .go(go), .step(step),
    .halted(halted), .disp_load(disp_load),
    .stall_cnt(stall_cnt), .cycle_cnt(cycle_cnt)
  );

  pipe_ctrl_param #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .stage_valid(stage_valid),
    .stage_ready(stage_ready4), .stage_flush(stage_flush4),
    .stall_req(stall_req), .flush_req(flush_req),
    .sys_req(sys_req), .sys_code(sys_code), .go(go), .step(step),
    .halted(halted4), .disp_load(disp_load4),
    .stall_cnt(stall_cnt4), .cycle_cnt(cycle_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit model_adv();
    return (stage_valid == {NS{1'b1}}) && !m_halt;
  endfunction

  // Model update at the active edge from the inputs held during the cycle.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_halt = 1'b0; m_step = 1'b0; m_cnt = 0; m_scnt = 0;
      end else begin
        bit a, hs;
        a  = model_adv();
        hs = sys_req && (sys_code != 32'h22);
        if (a) m_cnt++;
        if (a && stall_req) m_scnt++;
        if (m_halt) begin
          if (go)        begin m_halt = 1'b0; m_step = 1'b0; end
          else if (step) begin m_halt = 1'b0; m_step = 1'b1; end
        end else if (m_step) begin
          if (a && hs)   begin m_halt = 1'b1; m_step = 1'b0; end
          else if (go)   m_step = 1'b0;
          else if (a)    begin m_halt = 1'b1; m_step = 1'b0; end
        end else if (a && hs) begin
          m_halt = 1'b1;
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  initial begin
    forever begin
      logic [NS-1:0] er, ef;
      logic          ed;
      bit            a;
      @(negedge clk);
      a = model_adv();
      for (int i = 0; i < NS; i++) begin
        er[i] = a && !(stall_req && (i < 2));
        ef[i] = flush_req[i] || (stall_req && (i == 2));
      end
      ed = a && sys_req && (sys_code == 32'h22);
      chk("ready",   64'(stage_ready),  64'(er));
      chk("flush",   64'(stage_flush),  64'(ef));
      chk("disp",    64'(disp_load),    64'(ed));
      chk("halted",  64'(halted),       64'(m_halt));
      chk("cyc",     64'(cycle_cnt),    64'(sat(m_cnt, 32)));
      chk("stl",     64'(stall_cnt),    64'(sat(m_scnt, 32)));
      chk("ready4",  64'(stage_ready4), 64'(er));
      chk("halted4", 64'(halted4),      64'(m_halt));
      chk("cyc4",    64'(cycle_cnt4),   64'(sat(m_cnt, 4)));
      chk("stl4",    64'(stall_cnt4),   64'(sat(m_scnt, 4)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stage_valid = 5'h1F; stall_req = 1'b0; flush_req = 5'h00;
    sys_req = 1'b0; sys_code = 32'd0; go = 1'b0; step = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #2;
    chk("rst_cyc", 64'(cycle_cnt), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);

    // free running
    repeat (10) tick();
    #2;
    chk("run10_cyc", 64'(cycle_cnt), 64'd10);
    chk("run10_stl", 64'(stall_cnt), 64'd0);
    chk("run10_ready", 64'(stage_ready), 64'h1F);

    // single stall
    stall_req = 1'b1;
    #2;
    chk("stall_ready", 64'(stage_ready), 64'h1C);
    chk("stall_flush", 64'(stage_flush), 64'h04);
    tick();
    stall_req = 1'b0;
    #2;
    chk("stall_cnt1", 64'(stall_cnt), 64'd1);

    // halting syscall then go
    sys_req = 1'b1; sys_code = 32'd10;
    tick();
    sys_req = 1'b0;
    #2;
    chk("halt_h", 64'(halted), 64'd1);
    chk("halt_ready", 64'(stage_ready), 64'd0);
    repeat (2) tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    #2;
    chk("go_h", 64'(halted), 64'd0);
    chk("go_ready", 64'(stage_ready), 64'h1F);

    // single step
    sys_req = 1'b1; sys_code = 32'd10;
    tick();
    sys_req = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    #2;
    chk("step_ready", 64'(stage_ready), 64'h1F);
    tick();
    #2;
    chk("step_back_h", 64'(halted), 64'd1);
    chk("step_cyc", 64'(cycle_cnt), 64'd14);

    // display syscall
    go = 1'b1;
    tick();
    go = 1'b0;
    sys_req = 1'b1; sys_code = 32'h22;
    #2;
    chk("disp_on", 64'(disp_load), 64'd1);
    tick();
    stage_valid = 5'b10111;
    #2;
    chk("disp_invalid", 64'(disp_load), 64'd0);
    chk("disp_h", 64'(halted), 64'd0);
    tick();
    stage_valid = 5'h1F; sys_req = 1'b0;

    // saturation of the narrow counter
    repeat (20) tick();
    #2;
    chk("sat4_cyc", 64'(cycle_cnt4), 64'hF);
    chk("wide_cyc", 64'(cycle_cnt), 64'd35);

    // stall + flush request + halting syscall together
    stall_req = 1'b1; flush_req = 5'b00010; sys_req = 1'b1; sys_code = 32'd10;
    #2;
    chk("combo_flush", 64'(stage_flush), 64'h06);
    tick();
    stall_req = 1'b0; flush_req = 5'h00; sys_req = 1'b0;
    #2;
    chk("combo_h", 64'(halted), 64'd1);
    chk("combo_stl", 64'(stall_cnt), 64'd2);

    // step with an incomplete stage, then go leaves STEP
    stage_valid = 5'b01111; step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    #2;
    chk("stepwait_h", 64'(halted), 64'd0);
    go = 1'b1;
    tick();
    go = 1'b0; stage_valid = 5'h1F;
    tick();
    #2;
    chk("step_go_run", 64'(halted), 64'd0);

    // reset in the middle of STEP
    sys_req = 1'b1; sys_code = 32'd10;
    tick();
    sys_req = 1'b0; step = 1'b1; stage_valid = 5'h0F;
    tick();
    step = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; stage_valid = 5'h1F;
    #2;
    chk("mid_rst_h", 64'(halted), 64'd0);
    chk("mid_rst_cyc", 64'(cycle_cnt), 64'd0);
    chk("mid_rst_ready", 64'(stage_ready), 64'h1F);
    tick();
    #2;
    chk("post_rst_cyc", 64'(cycle_cnt), 64'd1);
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
